// File: rtl/min4_pkg.sv
// Shared constants and types for the 4-lane minimum group collector.
package min4_pkg;

    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam logic [WIDTH-1:0] PAD = {WIDTH{1'b1}};

    typedef logic [WIDTH-1:0] lane_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/min4_group_collector_if.sv
// Input sample stream and output group stream of the min4 group collector.
interface min4_group_collector_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [4*WIDTH-1:0]   out_lanes;
    logic [2:0]           out_count;
    logic [WIDTH-1:0]     out_min;
    logic [7:0]           out_seq;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_lanes, out_count, out_min, out_seq
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_lanes, out_count, out_min, out_seq
    );
endinterface

// File: rtl/min4_select.sv
// Combinational unsigned minimum of four packed lanes {a,b,c,d}; ties keep the earlier lane.
module min4_select #(
    parameter int WIDTH = 8
) (
    input  logic [4*WIDTH-1:0] lanes,
    output logic [WIDTH-1:0]   min_val
);
    logic [WIDTH-1:0] a, b, c, d, min_ab, min_cd;

    assign a = lanes[4*WIDTH-1:3*WIDTH];
    assign b = lanes[3*WIDTH-1:2*WIDTH];
    assign c = lanes[2*WIDTH-1:WIDTH];
    assign d = lanes[WIDTH-1:0];

    assign min_ab  = (b < a) ? b : a;
    assign min_cd  = (d < c) ? d : c;
    assign min_val = (min_cd < min_ab) ? min_cd : min_ab;
endmodule

// File: rtl/min4_group_collector.sv
// Packs a serial sample stream into 4-lane groups with count, sequence and minimum.
// Optional MIN4_GROUP_PASSTHRU_EN lets a new group start on the output handshake cycle.
module min4_group_collector #(
    parameter int               WIDTH = min4_pkg::WIDTH,
    parameter logic [WIDTH-1:0] PAD   = {WIDTH{1'b1}}
) (
    input logic                   clk,
    input logic                   reset,
    min4_group_collector_if.slave bus
);
    import min4_pkg::*;

    state_t             state, state_n;
    logic [1:0]         idx, idx_n;
    logic [4*WIDTH-1:0] lanes, lanes_n;
    logic [2:0]         count, count_n;
    logic [7:0]         seq, seq_n;
    logic               in_ready_c;
    logic               accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
            idx   <= 2'd0;
            lanes <= {4{PAD}};
            count <= 3'd0;
            seq   <= 8'd0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            lanes <= lanes_n;
            count <= count_n;
            seq   <= seq_n;
        end
    end

    always_comb begin
        in_ready_c = 1'b1;
        if (state == HOLD) begin
`ifdef MIN4_GROUP_PASSTHRU_EN
            in_ready_c = bus.out_ready;
`else
            in_ready_c = 1'b0;
`endif
        end
    end

    assign accept = bus.in_valid & in_ready_c;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        lanes_n = lanes;
        count_n = count;
        seq_n   = seq;
        case (state)
            FILL: begin
                if (accept) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (idx == 2'(i))
                            lanes_n[(LANES-1-i)*WIDTH +: WIDTH] = bus.in_data;
                    end
                    if (idx == 2'(LANES-1) || bus.in_last) begin
                        state_n = HOLD;
                        count_n = {1'b0, idx} + 3'd1;
                    end else begin
                        idx_n = idx + 2'd1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_n = FILL;
                    idx_n   = 2'd0;
                    lanes_n = {4{PAD}};
                    seq_n   = seq + 8'd1;
`ifdef MIN4_GROUP_PASSTHRU_EN
                    // Accept here implies the handshake, so the new sample opens the next group.
                    if (accept) begin
                        lanes_n = {bus.in_data, {3{PAD}}};
                        idx_n   = 2'd1;
                        if (bus.in_last) begin
                            state_n = HOLD;
                            count_n = 3'd1;
                        end
                    end
`endif
                end
            end
            default: state_n = FILL;
        endcase
    end

    min4_select #(.WIDTH(WIDTH)) u_min4_select (
        .lanes   (lanes),
        .min_val (bus.out_min)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state == HOLD);
    assign bus.out_lanes = lanes;
    assign bus.out_count = count;
    assign bus.out_seq   = seq;
endmodule

// File: tb/tb_min4_group_collector.sv
// Directed self-checking bench for min4_group_collector (default build).
module tb_min4_group_collector;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    min4_group_collector_if #(.WIDTH(8)) bus ();

    min4_group_collector #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Offer one sample and return #1 after the edge that accepted it.
    task automatic send(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check_val("send_ready_wait", 32'(n < 50), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        errors        = 0;
        checks        = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        do_reset();
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_out_count", 32'(bus.out_count), 32'd0);
        check_val("rst_out_seq",   32'(bus.out_seq),   32'd0);
        check_val("rst_in_ready",  32'(bus.in_ready),  32'd1);

        // Full group back-to-back
        send(8'h11, 1'b0);
        check_val("g0_no_early_valid", 32'(bus.out_valid), 32'd0);
        send(8'h02, 1'b0);
        send(8'h33, 1'b0);
        send(8'h04, 1'b0);
        check_val("g0_out_valid", 32'(bus.out_valid), 32'd1);
        check_val("g0_out_lanes", bus.out_lanes, 32'h11023304);
        check_val("g0_out_min",   32'(bus.out_min),   32'h02);
        check_val("g0_out_count", 32'(bus.out_count), 32'd4);
        check_val("g0_out_seq",   32'(bus.out_seq),   32'd0);
        check_val("g0_in_ready",  32'(bus.in_ready),  32'd0);
        tick();
        check_val("g0_after_valid", 32'(bus.out_valid), 32'd0);
        check_val("g0_after_seq",   32'(bus.out_seq),   32'd1);
        check_val("g0_after_lanes", bus.out_lanes, 32'hFFFFFFFF);

        // Partial group closed by in_last
        send(8'h40, 1'b0);
        send(8'h30, 1'b1);
        check_val("g1_out_valid", 32'(bus.out_valid), 32'd1);
        check_val("g1_out_lanes", bus.out_lanes, 32'h4030FFFF);
        check_val("g1_out_count", 32'(bus.out_count), 32'd2);
        check_val("g1_out_min",   32'(bus.out_min),   32'h30);
        check_val("g1_out_seq",   32'(bus.out_seq),   32'd1);
        tick();

        // Backpressure with a pending sample
        bus.out_ready = 1'b0;
        send(8'h50, 1'b0);
        send(8'h60, 1'b0);
        send(8'h70, 1'b0);
        send(8'h55, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check_val("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check_val("bp_out_lanes", bus.out_lanes, 32'h50607055);
            check_val("bp_out_min",   32'(bus.out_min),   32'h50);
            check_val("bp_out_count", 32'(bus.out_count), 32'd4);
            check_val("bp_out_seq",   32'(bus.out_seq),   32'd2);
            check_val("bp_in_ready",  32'(bus.in_ready),  32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check_val("bp_hs_valid", 32'(bus.out_valid), 32'd0);
        check_val("bp_hs_seq",   32'(bus.out_seq),   32'd3);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check_val("bp_next_valid", 32'(bus.out_valid), 32'd1);
        check_val("bp_next_lanes", bus.out_lanes, 32'h99FFFFFF);
        check_val("bp_next_count", 32'(bus.out_count), 32'd1);
        check_val("bp_next_min",   32'(bus.out_min),   32'h99);
        check_val("bp_next_seq",   32'(bus.out_seq),   32'd3);
        tick();
        check_val("bp_final_seq", 32'(bus.out_seq), 32'd4);

        // 256 single-sample groups, sequence wrap
        do_reset();
        for (int i = 0; i < 256; i++) begin
            d = 8'(i) ^ 8'h5A;
            send(d, 1'b1);
            check_val("seq_valid", 32'(bus.out_valid), 32'd1);
            check_val("seq_value", 32'(bus.out_seq),   32'(i));
            check_val("seq_min",   32'(bus.out_min),   32'(d));
            check_val("seq_lanes", bus.out_lanes, {d, 24'hFFFFFF});
        end
        tick();
        check_val("seq_wrap", 32'(bus.out_seq), 32'd0);

        // Reset mid-group discards partial lanes
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        do_reset();
        check_val("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check_val("mid_rst_seq",   32'(bus.out_seq),   32'd0);
        send(8'hFF, 1'b0);
        send(8'hFE, 1'b0);
        send(8'h80, 1'b0);
        send(8'h81, 1'b0);
        check_val("mid_valid", 32'(bus.out_valid), 32'd1);
        check_val("mid_lanes", bus.out_lanes, 32'hFFFE8081);
        check_val("mid_min",   32'(bus.out_min),   32'h80);
        check_val("mid_seq",   32'(bus.out_seq),   32'd0);
        check_val("mid_count", 32'(bus.out_count), 32'd4);
        tick();

        // in_last on the 4th sample behaves as a normal full group
        send(8'h07, 1'b0);
        send(8'h06, 1'b0);
        send(8'h09, 1'b0);
        send(8'h08, 1'b1);
        check_val("last4_count", 32'(bus.out_count), 32'd4);
        check_val("last4_min",   32'(bus.out_min),   32'h06);
        check_val("last4_lanes", bus.out_lanes, 32'h07060908);
        check_val("last4_seq",   32'(bus.out_seq),   32'd1);
        tick();
        check_val("last4_after_seq", 32'(bus.out_seq), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/min4_group_collector.md
Name: min4_group_collector

Overview:
- Upstream feeder for the 4-input minimum stage.
- Accepts a serial valid/ready stream of 8-bit samples and packs them into 4-lane groups {a,b,c,d}.
- Presents each group, with a lane count, sequence number and group minimum, on a valid/ready output.
- Partial groups, closed by in_last, are padded so the downstream minimum stays correct.

Parameters:
WIDTH, 8, sample/lane width in bits
PAD, {WIDTH{1'b1}}, fill value for unused lanes; must be the all-ones maximum so it never wins a minimum

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  sample offered
in_ready  output  1  block accepts the sample this cycle
in_data  input  WIDTH  sample value
in_last  input  1  qualified by in_valid; closes the current group after this sample
out_valid  output  1  group available
out_ready  input  1  consumer takes the group this cycle
out_lanes  output  4*WIDTH  packed {a,b,c,d}; a = first sample, in MSBs
out_count  output  3  valid lanes, 1..4
out_min  output  WIDTH  minimum of the four lanes; pads included, which are harmless
out_seq  output  8  group sequence number, wraps 255->0

Behaviour:
- Reset (synchronous; wins over every other event):
  - state=FILL, idx=0, all lanes=PAD.
  - out_valid=0, out_count=0, out_seq=0.
  - in_ready=1 after reset deasserts.
- FILL state:
  - in_ready=1.
  - Accept = in_valid & in_ready; on accept, lane[idx]<=in_data.
  - If idx==3 or in_last: go to HOLD next cycle, out_valid=1, out_count=idx+1.
  - Otherwise idx<=idx+1.
- HOLD state:
  - in_ready=0 (see Optional Feature).
  - out_lanes, out_count, out_min and out_seq are stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: lanes<=PAD, idx<=0, out_seq<=out_seq+1 (mod 256), out_valid<=0, state<=FILL.
- Latency: out_valid rises the cycle after the accept that closes the group.
  - Full group: 4 accept cycles, then 1 HOLD cycle minimum.
  - Throughput without the feature: 4 samples per 5 cycles.
- out_min:
  - Combinational from the registered lanes via the min4 sub-module.
  - Unsigned compare; on ties the earliest lane's value is used (values are equal, so no observable effect).
- in_last on the 4th sample: same as a normal full group, out_count=4.
- in_last on the first sample: out_count=1; lanes b,c,d=PAD; out_min=in_data.
- in_valid while in HOLD is ignored (in_ready=0); the sample stays with the producer.
- Reset mid-group: partially filled lanes are discarded; no output is produced for them.
- out_ready high while out_valid=0: no effect.

Optional Feature:
- Macro: MIN4_GROUP_PASSTHRU_EN.
- Defined:
  - In HOLD, in_ready=out_ready.
  - A sample accepted on the output-handshake cycle loads lane a (others=PAD), with idx<=1.
  - If that sample carries in_last, the state stays HOLD with out_valid=1, out_count=1 and out_seq incremented.
  - Sustained throughput: 1 sample/cycle.
- Undefined:
  - In HOLD, in_ready=0; one bubble cycle per group, as described in Behaviour.

Decomposition:
- Package min4_pkg:
  - WIDTH default constant, PAD constant, LANES=4.
  - typedef state_t enum {FILL, HOLD}.
  - typedef lane_t logic [WIDTH-1:0].
- Sub-module min4_select: combinational 4-lane unsigned minimum. It is instantiated once, producing out_min from the registered lanes.

Test Plan:
- Reset, then 4 samples 0x11,0x02,0x33,0x04 back-to-back with out_ready=1 -> out_valid high 1 cycle after the 4th accept; out_lanes=0x11023304, out_min=0x02, out_count=4, out_seq=0; in_ready low that cycle.
- Samples 0x40,0x30 with in_last on 0x30 -> out_lanes=0x4030FFFF, out_count=2, out_min=0x30.
- Group complete with out_ready held low for 6 cycles, in_valid=1 throughout -> outputs stable; in_ready=0; no sample lost; next group starts with the pending sample after the handshake.
- 256 single-sample in_last groups -> out_seq counts 0..255 then wraps to 0; out_min equals each sample.
- Reset asserted after 2 of 4 samples -> no output; next 4 samples 0xFF,0xFE,0x80,0x81 give out_min=0x80, out_seq=0.
- With MIN4_GROUP_PASSTHRU_EN, 8 consecutive samples 0x08..0x01, out_ready=1 -> two groups on consecutive handshakes; no bubble; min 0x05 then 0x01.
